// File: rtl/multi_bit_sync_filt_pkg.sv
// Shared constants and helpers for the multi-bit synchronizer / glitch filter.
// Optional edge detection is enabled by MULTI_BIT_SYNC_EDGE_DET_EN.
package multi_bit_sync_filt_pkg;

  localparam int unsigned SYNC_MIN_STAGES = 2;
  localparam int unsigned SYNC_MIN_FILT   = 1;

  // Counter must hold 0..filt_len-1, and never be narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned filt_len);
    return (filt_len <= 2) ? 1 : $clog2(filt_len);
  endfunction

endpackage

// File: rtl/multi_bit_sync_filt_if.sv
// Level/edge bundle between async sources and the multi-bit synchronizer.
// Edge signals are constant 0 unless MULTI_BIT_SYNC_EDGE_DET_EN is defined.
interface multi_bit_sync_filt_if #(
  parameter int unsigned NUM_CH = 4
);

  logic [NUM_CH-1:0] Async_data;
  logic [NUM_CH-1:0] sync_data;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic              changed;

  modport master (
    output Async_data,
    input  sync_data,
    input  rise_pulse,
    input  fall_pulse,
    input  changed
  );

  modport slave (
    input  Async_data,
    output sync_data,
    output rise_pulse,
    output fall_pulse,
    output changed
  );

endinterface

// File: rtl/multi_bit_sync_filt_sync_chan_filter.sv
// Single-channel stable-count glitch filter with optional registered edge pulses
// (edge ports exist only when MULTI_BIT_SYNC_EDGE_DET_EN is defined).
module multi_bit_sync_filt_sync_chan_filter
  import multi_bit_sync_filt_pkg::*;
#(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic CLK,
  input  logic Reset,
  input  logic s,
  output logic filt
`ifdef MULTI_BIT_SYNC_EDGE_DET_EN
  ,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic accept
`endif
);

  localparam int unsigned      CNT_W  = cnt_width(FILT_LEN);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(FILT_LEN - 1);

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where s agrees with the accepted level discards the partial count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (s != filt_q) begin
      if (cnt_q == CntMax) begin
        filt_d = s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;

`ifdef MULTI_BIT_SYNC_EDGE_DET_EN
  logic rise_q, fall_q;

  // Registered from filt_d so the pulse lines up with the new filt value.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= filt_d & ~filt_q;
      fall_q <= ~filt_d & filt_q;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign accept     = filt_d ^ filt_q;
`endif

endmodule

// File: rtl/multi_bit_sync_filt.sv
// NUM_CH independent async levels -> NUM_STAGES flop chains -> glitch filters.
// Define MULTI_BIT_SYNC_EDGE_DET_EN to generate rise/fall/changed; else tied to 0.
module multi_bit_sync_filt
  import multi_bit_sync_filt_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned FILT_LEN   = 4
) (
  input logic                  CLK,
  input logic                  Reset,
  multi_bit_sync_filt_if.slave bus
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("NUM_CH must be at least 1");
  end
  if (NUM_STAGES < SYNC_MIN_STAGES) begin : g_bad_num_stages
    $error("NUM_STAGES must be at least 2");
  end
  if (FILT_LEN < SYNC_MIN_FILT) begin : g_bad_filt_len
    $error("FILT_LEN must be at least 1");
  end

  logic [NUM_CH-1:0] filt_vec;
`ifdef MULTI_BIT_SYNC_EDGE_DET_EN
  logic [NUM_CH-1:0] rise_vec;
  logic [NUM_CH-1:0] fall_vec;
  logic [NUM_CH-1:0] accept_vec;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [NUM_STAGES-1:0] chain_q;

    always_ff @(posedge CLK) begin
      if (Reset) begin
        chain_q <= '0;
      end else begin
        chain_q <= {chain_q[NUM_STAGES-2:0], bus.Async_data[i]};
      end
    end

    multi_bit_sync_filt_sync_chan_filter #(
      .FILT_LEN (FILT_LEN)
    ) u_filt (
      .CLK        (CLK),
      .Reset      (Reset),
      .s          (chain_q[NUM_STAGES-1]),
      .filt       (filt_vec[i])
`ifdef MULTI_BIT_SYNC_EDGE_DET_EN
      ,
      .rise_pulse (rise_vec[i]),
      .fall_pulse (fall_vec[i]),
      .accept     (accept_vec[i])
`endif
    );
  end

  assign bus.sync_data = filt_vec;

`ifdef MULTI_BIT_SYNC_EDGE_DET_EN
  logic changed_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |accept_vec;
    end
  end

  assign bus.rise_pulse = rise_vec;
  assign bus.fall_pulse = fall_vec;
  assign bus.changed    = changed_q;
`else
  assign bus.rise_pulse = '0;
  assign bus.fall_pulse = '0;
  assign bus.changed    = 1'b0;
`endif

endmodule

// File: tb/tb_multi_bit_sync_filt.sv
// Scoreboard bench for multi_bit_sync_filt: default config plus NUM_STAGES=3/FILT_LEN=1.
// Edge expectations follow MULTI_BIT_SYNC_EDGE_DET_EN (all-zero when undefined).
module tb_multi_bit_sync_filt;

`ifdef MULTI_BIT_SYNC_EDGE_DET_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] sync;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [3:0] cur_a = 4'h0;

  always #5 clk = ~clk;

  multi_bit_sync_filt_if #(.NUM_CH(4)) if_a ();
  multi_bit_sync_filt_if #(.NUM_CH(4)) if_b ();

  multi_bit_sync_filt #(
    .NUM_CH     (4),
    .NUM_STAGES (2),
    .FILT_LEN   (4)
  ) dut_a (
    .CLK   (clk),
    .Reset (reset_a),
    .bus   (if_a)
  );

  multi_bit_sync_filt #(
    .NUM_CH     (4),
    .NUM_STAGES (3),
    .FILT_LEN   (1)
  ) dut_b (
    .CLK   (clk),
    .Reset (reset_b),
    .bus   (if_b)
  );

  // Expected output record; edge fields are forced to 0 when edge detection is off.
  function automatic exp_t mk(input logic [3:0] s, input logic [3:0] r, input logic [3:0] f);
    mk = {s, r & {4{EdgeEn}}, f & {4{EdgeEn}}, EdgeEn & (|(r | f))};
  endfunction

  task automatic test_reset();
    exp_t e, obs;
    reset_a = 1'b1;
    if_a.Async_data = 4'hF;
    for (int k = 1; k <= 3; k++) q_a.push_back(mk(4'h0, 4'h0, 4'h0));
    for (int k = 1; k <= 5; k++) q_a.push_back(mk(4'h0, 4'h0, 4'h0));
    q_a.push_back(mk(4'hF, 4'hF, 4'h0));
    q_a.push_back(mk(4'hF, 4'h0, 4'h0));
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      obs = {if_a.sync_data, if_a.rise_pulse, if_a.fall_pulse, if_a.changed};
      e = q_a.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset[%0d]: got sync=%h rise=%h fall=%h chg=%b, want sync=%h rise=%h fall=%h chg=%b",
                 k, obs.sync, obs.rise, obs.fall, obs.chg, e.sync, e.rise, e.fall, e.chg);
      end
      if (k == 3) reset_a = 1'b0;
    end
    cur_a = 4'hF;
  endtask

  task automatic test_step();
    logic [3:0] vals [3] = '{4'h0, 4'h1, 4'h0};
    exp_t e, obs;
    foreach (vals[j]) begin
      for (int k = 1; k <= 5; k++) q_a.push_back(mk(cur_a, 4'h0, 4'h0));
      q_a.push_back(mk(vals[j], vals[j] & ~cur_a, ~vals[j] & cur_a));
      q_a.push_back(mk(vals[j], 4'h0, 4'h0));
      if_a.Async_data = vals[j];
      cur_a = vals[j];
      for (int k = 1; k <= 7; k++) begin
        @(negedge clk);
        obs = {if_a.sync_data, if_a.rise_pulse, if_a.fall_pulse, if_a.changed};
        e = q_a.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL step%0d[%0d]: got sync=%h rise=%h fall=%h chg=%b, want sync=%h rise=%h fall=%h chg=%b",
                   j, k, obs.sync, obs.rise, obs.fall, obs.chg, e.sync, e.rise, e.fall, e.chg);
        end
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e, obs;
    int   n;
    for (int w = 3; w <= 4; w++) begin
      if (w == 3) begin
        n = 10;
        for (int k = 1; k <= n; k++) q_a.push_back(mk(4'h0, 4'h0, 4'h0));
      end else begin
        n = 11;
        for (int k = 1; k <= 5; k++) q_a.push_back(mk(4'h0, 4'h0, 4'h0));
        q_a.push_back(mk(4'h2, 4'h2, 4'h0));
        for (int k = 1; k <= 3; k++) q_a.push_back(mk(4'h2, 4'h0, 4'h0));
        q_a.push_back(mk(4'h0, 4'h0, 4'h2));
        q_a.push_back(mk(4'h0, 4'h0, 4'h0));
      end
      if_a.Async_data = 4'h2;
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        obs = {if_a.sync_data, if_a.rise_pulse, if_a.fall_pulse, if_a.changed};
        e = q_a.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL glitch_w%0d[%0d]: got sync=%h rise=%h fall=%h chg=%b, want sync=%h rise=%h fall=%h chg=%b",
                   w, k, obs.sync, obs.rise, obs.fall, obs.chg, e.sync, e.rise, e.fall, e.chg);
        end
        if_a.Async_data = (k + 1 <= w) ? 4'h2 : 4'h0;
      end
    end
    cur_a = 4'h0;
  endtask

  task automatic test_simultaneous();
    logic [3:0] vals [2] = '{4'h8, 4'h4};
    exp_t e, obs;
    foreach (vals[j]) begin
      for (int k = 1; k <= 5; k++) q_a.push_back(mk(cur_a, 4'h0, 4'h0));
      q_a.push_back(mk(vals[j], vals[j] & ~cur_a, ~vals[j] & cur_a));
      q_a.push_back(mk(vals[j], 4'h0, 4'h0));
      if_a.Async_data = vals[j];
      cur_a = vals[j];
      for (int k = 1; k <= 7; k++) begin
        @(negedge clk);
        obs = {if_a.sync_data, if_a.rise_pulse, if_a.fall_pulse, if_a.changed};
        e = q_a.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL simul%0d[%0d]: got sync=%h rise=%h fall=%h chg=%b, want sync=%h rise=%h fall=%h chg=%b",
                   j, k, obs.sync, obs.rise, obs.fall, obs.chg, e.sync, e.rise, e.fall, e.chg);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, obs;
    for (int k = 1; k <= 4; k++) q_a.push_back(mk(4'h4, 4'h0, 4'h0));
    for (int k = 1; k <= 6; k++) q_a.push_back(mk(4'h0, 4'h0, 4'h0));
    q_a.push_back(mk(4'h5, 4'h5, 4'h0));
    q_a.push_back(mk(4'h5, 4'h0, 4'h0));
    if_a.Async_data = 4'h5;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      obs = {if_a.sync_data, if_a.rise_pulse, if_a.fall_pulse, if_a.changed};
      e = q_a.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_mid[%0d]: got sync=%h rise=%h fall=%h chg=%b, want sync=%h rise=%h fall=%h chg=%b",
                 k, obs.sync, obs.rise, obs.fall, obs.chg, e.sync, e.rise, e.fall, e.chg);
      end
      if (k == 4) reset_a = 1'b1;
      if (k == 5) reset_a = 1'b0;
    end
    cur_a = 4'h5;
  endtask

  task automatic test_cfg_short();
    exp_t e, obs;
    reset_b = 1'b1;
    if_b.Async_data = 4'h0;
    for (int k = 1; k <= 2; k++) q_b.push_back(mk(4'h0, 4'h0, 4'h0));
    // One-cycle input pulse on ch2, then a held step on ch1.
    for (int k = 1; k <= 3; k++) q_b.push_back(mk(4'h0, 4'h0, 4'h0));
    q_b.push_back(mk(4'h4, 4'h4, 4'h0));
    q_b.push_back(mk(4'h0, 4'h0, 4'h4));
    q_b.push_back(mk(4'h0, 4'h0, 4'h0));
    for (int k = 1; k <= 3; k++) q_b.push_back(mk(4'h0, 4'h0, 4'h0));
    q_b.push_back(mk(4'h2, 4'h2, 4'h0));
    q_b.push_back(mk(4'h2, 4'h0, 4'h0));
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      obs = {if_b.sync_data, if_b.rise_pulse, if_b.fall_pulse, if_b.changed};
      e = q_b.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL cfg_short[%0d]: got sync=%h rise=%h fall=%h chg=%b, want sync=%h rise=%h fall=%h chg=%b",
                 k, obs.sync, obs.rise, obs.fall, obs.chg, e.sync, e.rise, e.fall, e.chg);
      end
      if (k == 2) begin
        reset_b = 1'b0;
        if_b.Async_data = 4'h4;
      end
      if (k == 3) if_b.Async_data = 4'h0;
      if (k == 8) if_b.Async_data = 4'h2;
    end
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    if_a.Async_data = 4'h0;
    if_b.Async_data = 4'h0;
    test_reset();
    test_step();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_cfg_short();
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, want 0/0", q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
